// File: rtl/fft_peak_tracker_if.sv
// Stream and result bundle between the FFT magnitude stage, the peak tracker
// and the pitch logic.
interface fft_peak_tracker_if #(
  parameter int NUM_PEAKS = 3
);
  logic                    frame_start;
  logic                    bin_valid;
  logic [31:0]             amplitude;
  logic [16*NUM_PEAKS-1:0] peak_freq;
  logic [32*NUM_PEAKS-1:0] peak_amp;
  logic [NUM_PEAKS-1:0]    peak_valid;
  logic                    result_valid;
  logic                    busy;
  logic                    overrun;

  modport master (
    output frame_start, bin_valid, amplitude,
    input  peak_freq, peak_amp, peak_valid, result_valid, busy, overrun
  );

  modport slave (
    input  frame_start, bin_valid, amplitude,
    output peak_freq, peak_amp, peak_valid, result_valid, busy, overrun
  );
endinterface

// File: rtl/fft_peak_tracker.sv
// Top-K spectral peak tracker: keeps a sorted list of the strongest bins of a
// streamed FFT frame and publishes them, converted to Hz, once per frame.
module fft_peak_tracker #(
  parameter int          FFT_WIDTH       = 16384,
  parameter int          FFT_WIDTH_LOG_2 = 14,
  parameter int          SAMPLE_RATE     = 24000,
  parameter int          NUM_PEAKS       = 3,
  parameter int          MIN_BIN         = 1,
  parameter int          MAX_BIN         = FFT_WIDTH / 2 - 1,
  parameter logic [31:0] THRESHOLD       = 32'd0
) (
  input logic               clk,
  input logic               reset,
  fft_peak_tracker_if.slave bus
);
  localparam int IDX_W = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam int BIN_W = FFT_WIDTH_LOG_2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_r;
  logic [BIN_W-1:0]     bin_cnt_r;
  logic [IDX_W-1:0]     conv_idx_r;
  logic [31:0]          list_amp_r [NUM_PEAKS];
  logic [BIN_W-1:0]     list_bin_r [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] list_vld_r;
  logic [15:0]          shd_freq_r [NUM_PEAKS];
  logic [31:0]          shd_amp_r  [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] shd_vld_r;

  logic [16*NUM_PEAKS-1:0] peak_freq_r;
  logic [32*NUM_PEAKS-1:0] peak_amp_r;
  logic [NUM_PEAKS-1:0]    peak_valid_r;
  logic                    result_valid_r;
  logic                    busy_r;
  logic                    overrun_r;

  logic                 restart_s;
  logic                 cand_s;
  int                   idx_s;
  logic [NUM_PEAKS-1:0] gt_s;
  logic [NUM_PEAKS-1:0] prev_gt_s;
  logic [31:0]          sh_amp_s  [NUM_PEAKS];
  logic [BIN_W-1:0]     sh_bin_s  [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] sh_vld_s;
  logic [31:0]          nxt_amp_s [NUM_PEAKS];
  logic [BIN_W-1:0]     nxt_bin_s [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] nxt_vld_s;
  logic [47:0]          prod_s;
  logic [15:0]          conv_freq_s;

  assign bus.peak_freq    = peak_freq_r;
  assign bus.peak_amp     = peak_amp_r;
  assign bus.peak_valid   = peak_valid_r;
  assign bus.result_valid = result_valid_r;
  assign bus.busy         = busy_r;
  assign bus.overrun      = overrun_r;

  // Candidate qualification, parallel insertion against the current list, and Hz conversion.
  always_comb begin
    restart_s = bus.bin_valid && bus.frame_start;
    idx_s     = int'(bin_cnt_r);
    cand_s    = (state_r == SCAN) && bus.bin_valid && !bus.frame_start &&
                (idx_s != 0) && (idx_s >= MIN_BIN) && (idx_s <= MAX_BIN) &&
                (bus.amplitude > THRESHOLD);
    for (int i = 0; i < NUM_PEAKS; i++) begin
      gt_s[i] = !list_vld_r[i] || (bus.amplitude > list_amp_r[i]);
    end
    // The list is sorted with invalid slots last, so gt_s is a thermometer code.
    prev_gt_s   = gt_s << 1;
    sh_amp_s[0] = 32'd0;
    sh_bin_s[0] = '0;
    sh_vld_s[0] = 1'b0;
    for (int i = 1; i < NUM_PEAKS; i++) begin
      sh_amp_s[i] = list_amp_r[i-1];
      sh_bin_s[i] = list_bin_r[i-1];
      sh_vld_s[i] = list_vld_r[i-1];
    end
    for (int i = 0; i < NUM_PEAKS; i++) begin
      if (!cand_s) begin
        nxt_amp_s[i] = list_amp_r[i];
        nxt_bin_s[i] = list_bin_r[i];
        nxt_vld_s[i] = list_vld_r[i];
      end else if (prev_gt_s[i]) begin
        nxt_amp_s[i] = sh_amp_s[i];
        nxt_bin_s[i] = sh_bin_s[i];
        nxt_vld_s[i] = sh_vld_s[i];
      end else if (gt_s[i]) begin
        nxt_amp_s[i] = bus.amplitude;
        nxt_bin_s[i] = bin_cnt_r;
        nxt_vld_s[i] = 1'b1;
      end else begin
        nxt_amp_s[i] = list_amp_r[i];
        nxt_bin_s[i] = list_bin_r[i];
        nxt_vld_s[i] = list_vld_r[i];
      end
    end
    prod_s      = 48'(list_bin_r[conv_idx_r]) * 48'(SAMPLE_RATE);
    conv_freq_s = 16'(prod_s >> FFT_WIDTH_LOG_2);
  end

  // Frame FSM with list, shadow and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      bin_cnt_r      <= '0;
      conv_idx_r     <= '0;
      list_vld_r     <= '0;
      shd_vld_r      <= '0;
      peak_freq_r    <= '0;
      peak_amp_r     <= '0;
      peak_valid_r   <= '0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      overrun_r      <= 1'b0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        list_amp_r[i] <= 32'd0;
        list_bin_r[i] <= '0;
        shd_freq_r[i] <= 16'd0;
        shd_amp_r[i]  <= 32'd0;
      end
    end else begin
      result_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (restart_s) begin
            list_vld_r <= '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
              list_amp_r[i] <= 32'd0;
              list_bin_r[i] <= '0;
            end
            bin_cnt_r <= BIN_W'(1);
            state_r   <= SCAN;
            busy_r    <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        SCAN: begin
          if (restart_s) begin
            list_vld_r <= '0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
              list_amp_r[i] <= 32'd0;
              list_bin_r[i] <= '0;
            end
            bin_cnt_r <= BIN_W'(1);
          end else if (bus.bin_valid) begin
            list_vld_r <= nxt_vld_s;
            for (int i = 0; i < NUM_PEAKS; i++) begin
              list_amp_r[i] <= nxt_amp_s[i];
              list_bin_r[i] <= nxt_bin_s[i];
            end
            bin_cnt_r <= bin_cnt_r + BIN_W'(1);
            if (idx_s == MAX_BIN) begin
              state_r    <= CONVERT;
              conv_idx_r <= '0;
            end else begin
              state_r <= SCAN;
            end
          end else begin
            state_r <= SCAN;
          end
        end
        CONVERT: begin
          overrun_r             <= restart_s;
          shd_vld_r[conv_idx_r] <= list_vld_r[conv_idx_r];
          if (list_vld_r[conv_idx_r]) begin
            shd_freq_r[conv_idx_r] <= conv_freq_s;
            shd_amp_r[conv_idx_r]  <= list_amp_r[conv_idx_r];
          end else begin
            shd_freq_r[conv_idx_r] <= 16'd0;
            shd_amp_r[conv_idx_r]  <= 32'd0;
          end
          if (conv_idx_r == IDX_W'(NUM_PEAKS - 1)) begin
            state_r <= DONE;
          end else begin
            conv_idx_r <= conv_idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          overrun_r <= restart_s;
          for (int i = 0; i < NUM_PEAKS; i++) begin
            peak_freq_r[16*i +: 16] <= shd_freq_r[i];
            peak_amp_r[32*i +: 32]  <= shd_amp_r[i];
          end
          peak_valid_r   <= shd_vld_r;
          result_valid_r <= 1'b1;
          busy_r         <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_peak_tracker.sv
// Scoreboard bench: three tracker instances (default, narrow window, raised
// threshold) driven by directed frames; a negedge monitor checks every result.
module tb_fft_peak_tracker;
  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        bin_valid;
  logic [31:0] amplitude;
  logic [1:0]  sel;
  int          cyc = 0;
  int          last_edge = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [47:0] freq;
    logic [95:0] amp;
    logic [2:0]  vld;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  fft_peak_tracker_if #(.NUM_PEAKS(3)) ifa ();
  fft_peak_tracker_if #(.NUM_PEAKS(3)) ifb ();
  fft_peak_tracker_if #(.NUM_PEAKS(3)) ifc ();

  assign ifa.frame_start = frame_start & (sel == 2'd0);
  assign ifa.bin_valid   = bin_valid & (sel == 2'd0);
  assign ifa.amplitude   = amplitude;
  assign ifb.frame_start = frame_start & (sel == 2'd1);
  assign ifb.bin_valid   = bin_valid & (sel == 2'd1);
  assign ifb.amplitude   = amplitude;
  assign ifc.frame_start = frame_start & (sel == 2'd2);
  assign ifc.bin_valid   = bin_valid & (sel == 2'd2);
  assign ifc.amplitude   = amplitude;

  fft_peak_tracker dut_a (.clk(clk), .reset(reset), .bus(ifa));
  fft_peak_tracker #(.MIN_BIN(1000), .MAX_BIN(2000)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  fft_peak_tracker #(.THRESHOLD(32'd50)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, expv);
    end
  endtask

  function automatic logic [31:0] amp_for(input int mode, input int i);
    case (mode)
      0: amp_for = (i == 683) ? 32'd500 : (i == 1365) ? 32'd900 : (i == 2048) ? 32'd700 : 32'd10;
      1: amp_for = (i == 0) ? 32'd5000 : (i == 100 || i == 200) ? 32'd1000 : 32'd0;
      2: amp_for = 32'(i % 51);
      3: amp_for = (i == 500) ? 32'd9999 : (i == 1500) ? 32'd10 : 32'd0;
      4: amp_for = (i == 50) ? 32'd5000 : 32'd0;
      5: amp_for = (i == 10) ? 32'd77 : (i == 4000) ? 32'd60 : 32'd0;
      6: amp_for = (i == 8191) ? 32'd1 : 32'd0;
      default: amp_for = (i == 200) ? 32'd123456 : 32'd7;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bin_valid   = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic beat(input logic fs, input logic [31:0] a);
    @(negedge clk);
    frame_start = fs;
    bin_valid   = 1'b1;
    amplitude   = a;
  endtask

  task automatic run_frame(input int mode, input int last_bin, input bit gaps);
    for (int i = 0; i <= last_bin; i++) begin
      if (gaps && ($urandom_range(0, 7) == 0)) idle($urandom_range(1, 3));
      beat(i == 0, amp_for(mode, i));
      if (i == last_bin) last_edge = cyc + 1;
    end
    idle(1);
  endtask

  task automatic push(input int d, input logic [47:0] f, input logic [95:0] a, input logic [2:0] v);
    exp_t e;
    e.freq = f;
    e.amp  = a;
    e.vld  = v;
    e.cyc  = last_edge + 4;
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic mon(input int d, input logic rv, input logic [47:0] f, input logic [95:0] a, input logic [2:0] v);
    exp_t e;
    bit   have;
    if (rv === 1'b1) begin
      have = 1'b0;
      case (d)
        0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
        1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
        default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        total++;
        bad++;
        $display("FAIL dut%0d_unexpected_result: actual=result_valid at cycle %0d required=none", d, cyc);
      end else begin
        chk($sformatf("dut%0d_freq", d), f, e.freq);
        chk($sformatf("dut%0d_amp", d), a, e.amp);
        chk($sformatf("dut%0d_valid", d), v, e.vld);
        chk($sformatf("dut%0d_latency", d), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ifa.result_valid, ifa.peak_freq, ifa.peak_amp, ifa.peak_valid);
    mon(1, ifb.result_valid, ifb.peak_freq, ifb.peak_amp, ifb.peak_valid);
    mon(2, ifc.result_valid, ifc.peak_freq, ifc.peak_amp, ifc.peak_valid);
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_freq"}, ifa.peak_freq, 128'd0);
    chk({tag, "_amp"}, ifa.peak_amp, 128'd0);
    chk({tag, "_valid"}, ifa.peak_valid, 128'd0);
    chk({tag, "_rv"}, ifa.result_valid, 128'd0);
    chk({tag, "_busy"}, ifa.busy, 128'd0);
    chk({tag, "_overrun"}, ifa.overrun, 128'd0);
  endtask

  initial begin
    reset       = 1'b1;
    sel         = 2'd0;
    frame_start = 1'b0;
    bin_valid   = 1'b0;
    amplitude   = 32'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // window 1000..2000: the out-of-window 9999 at bin 500 is ignored
    sel = 2'd1;
    run_frame(3, 2000, 1'b0);
    push(1, {16'd0, 16'd0, 16'd2197}, {32'd0, 32'd0, 32'd10}, 3'b001);
    idle(8);

    // threshold 50, nothing qualifies
    sel = 2'd2;
    run_frame(2, 8191, 1'b0);
    push(2, 48'd0, 96'd0, 3'b000);
    idle(8);

    // main three-peak frame
    sel = 2'd0;
    run_frame(0, 8191, 1'b0);
    push(0, {16'd1000, 16'd3000, 16'd1999}, {32'd500, 32'd700, 32'd900}, 3'b111);
    idle(8);

    // aborted frame with gaps, restarted at bin 300
    run_frame(4, 299, 1'b1);
    run_frame(5, 8191, 1'b1);
    push(0, {16'd0, 16'd5859, 16'd14}, {32'd0, 32'd60, 32'd77}, 3'b011);
    idle(8);

    // peak on MAX_BIN itself, then frame_start dropped during CONVERT
    run_frame(6, 8191, 1'b0);
    push(0, {16'd0, 16'd0, 16'd11998}, {32'd0, 32'd0, 32'd1}, 3'b001);
    beat(1'b1, 32'd5);
    @(negedge clk);
    bin_valid   = 1'b0;
    frame_start = 1'b0;
    chk("overrun_pulse", ifa.overrun, 128'd1);
    @(negedge clk);
    chk("overrun_clear", ifa.overrun, 128'd0);
    idle(8);
    chk("busy_idle", ifa.busy, 128'd0);

    // reset mid-SCAN, then stray beats without frame_start
    for (int i = 0; i < 500; i++) beat(i == 0, amp_for(7, i));
    chk("busy_scan", ifa.busy, 128'd1);
    @(negedge clk);
    bin_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("midreset");
    for (int i = 0; i < 20; i++) beat(1'b0, 32'd999);
    idle(4);
    chk("stray_ignored_busy", ifa.busy, 128'd0);

    // tie: earlier bin ranks higher, bin 0 never counts
    run_frame(1, 8191, 1'b0);
    push(0, {16'd0, 16'd292, 16'd146}, {32'd0, 32'd1000, 32'd1000}, 3'b011);
    idle(10);

    chk("pending_results", 128'(qa.size() + qb.size() + qc.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
